branch_train_queue: RTL and testbench

- Sits directly downstream of the gshare predictor.
- Captures every issued prediction (pc, global history, predicted direction) in an in-order queue until the execute stage resolves the branch.
- On resolution it emits one registered training beat into the predictor's train_* port, including the mispredict flag and the history to restore.
- On mispredict it discards all younger (wrong-path) entries.

---
 rtl/branch_train_queue.sv | 136 +++++++++++++
 tb/tb_branch_train_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_train_queue.sv
// branch_train_queue
//   In-order queue between the gshare predictor and the execute stage. Every
//   issued prediction (pc, history, predicted direction) is captured at the
//   tail; when execute resolves the oldest branch, the head entry is turned
//   into one registered training beat for the predictor's train_* port.
//   A mispredicting resolve trains the head and discards every younger
//   (wrong-path) entry. flush clears the queue with highest priority.
//
// Ports
//   clk, areset        rising-edge clock, asynchronous active-high reset
//   alloc_valid/_pc/_history/_taken  prediction issued this cycle
//   alloc_ready        queue can accept an entry (!full, registered only)
//   resolve_valid/_taken  oldest in-flight branch resolved, actual direction
//   flush              pipeline flush; clears queue, ignores alloc/resolve
//   train_valid        one-cycle training pulse; other train_* hold otherwise
//   train_taken/_mispredicted/_history/_pc  training beat contents
//   count/empty/full   occupancy
//   resolve_err        one-cycle pulse: resolve_valid seen while empty
module branch_train_queue #(
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     alloc_valid,
  input  logic [PC_W-1:0]          alloc_pc,
  input  logic [HIST_W-1:0]        alloc_history,
  input  logic                     alloc_taken,
  output logic                     alloc_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     train_valid,
  output logic                     train_taken,
  output logic                     train_mispredicted,
  output logic [HIST_W-1:0]        train_history,
  output logic [PC_W-1:0]          train_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     resolve_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry storage; contents are don't-care after reset.
  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [HIST_W-1:0] hist_mem  [DEPTH];
  logic              taken_mem [DEPTH];

  logic [PW-1:0] head_q, tail_q, head_d, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic resolve_acc;
  logic mispredict_now;
  logic alloc_acc;
  logic err_now;

  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;

  // Acceptance: flush dominates; a mispredict kills the same-cycle alloc
  // because that alloc is itself on the wrong path.
  always_comb begin
    resolve_acc    = resolve_valid && !empty && !flush;
    mispredict_now = resolve_acc && (resolve_taken != taken_mem[head_q]);
    alloc_acc      = alloc_valid && !full && !flush && !mispredict_now;
    err_now        = resolve_valid && empty && !flush;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush || mispredict_now) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (resolve_acc) head_d = head_q + PW'(1);
      if (alloc_acc)   tail_d = tail_q + PW'(1);
      case ({alloc_acc, resolve_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_acc) begin
      pc_mem[tail_q]    <= alloc_pc;
      hist_mem[tail_q]  <= alloc_history;
      taken_mem[tail_q] <= alloc_taken;
    end
  end

  // Training beat: train_valid pulses for one cycle, payload holds between beats.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      train_valid        <= 1'b0;
      train_taken        <= 1'b0;
      train_mispredicted <= 1'b0;
      train_history      <= '0;
      train_pc           <= '0;
      resolve_err        <= 1'b0;
    end else begin
      train_valid <= resolve_acc;
      resolve_err <= err_now;
      if (resolve_acc) begin
        train_taken        <= resolve_taken;
        train_mispredicted <= mispredict_now;
        train_history      <= hist_mem[head_q];
        train_pc           <= pc_mem[head_q];
      end
    end
  end

endmodule

// File: tb/tb_branch_train_queue.sv
module tb_branch_train_queue;

  localparam int PC_W  = 7;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic alloc_valid = 1'b0;
  logic [PC_W-1:0] alloc_pc = '0;
  logic [PC_W-1:0] alloc_history = '0;
  logic alloc_taken = 1'b0;
  logic alloc_ready;
  logic resolve_valid = 1'b0;
  logic resolve_taken = 1'b0;
  logic flush = 1'b0;
  logic train_valid, train_taken, train_mispredicted;
  logic [PC_W-1:0] train_history, train_pc;
  logic [3:0] count;
  logic empty, full, resolve_err;

  branch_train_queue #(.PC_W(PC_W), .HIST_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .areset(areset),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_history(alloc_history),
    .alloc_taken(alloc_taken), .alloc_ready(alloc_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .train_valid(train_valid), .train_taken(train_taken),
    .train_mispredicted(train_mispredicted), .train_history(train_history),
    .train_pc(train_pc), .count(count), .empty(empty), .full(full),
    .resolve_err(resolve_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] hist;
    logic            tk;
  } ent_t;

  typedef struct packed {
    logic            tk;
    logic            mis;
    logic [PC_W-1:0] hist;
    logic [PC_W-1:0] pc;
  } beat_t;

  // Reference model: in-flight branches in program order.
  ent_t  mq[$];
  beat_t sb[$];

  // Model's prediction of the state after the next clock edge.
  int   nx_count = 0;
  logic nx_err = 1'b0;
  logic nx_tv  = 1'b0;
  // Expected DUT state, latched at the edge the prediction refers to.
  int   exp_count = 0;
  logic exp_err = 1'b0;
  logic exp_tv  = 1'b0;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      exp_count <= 0;
      exp_err   <= 1'b0;
      exp_tv    <= 1'b0;
    end else begin
      exp_count <= nx_count;
      exp_err   <= nx_err;
      exp_tv    <= nx_tv;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  beat_t last = '0;

  // Monitor: compares DUT outputs on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    if (areset) last = '0;
    chk("count", 32'(count), 32'(exp_count));
    chk("empty", 32'(empty), 32'(exp_count == 0));
    chk("full", 32'(full), 32'(exp_count == DEPTH));
    chk("alloc_ready", 32'(alloc_ready), 32'(exp_count != DEPTH));
    chk("resolve_err", 32'(resolve_err), 32'(exp_err));
    chk("train_valid", 32'(train_valid), 32'(exp_tv));
    if (exp_tv) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 32'(0), 32'(1));
      end else begin
        b = sb.pop_front();
        if (train_valid) begin
          chk("train_taken", 32'(train_taken), 32'(b.tk));
          chk("train_mispredicted", 32'(train_mispredicted), 32'(b.mis));
          chk("train_history", 32'(train_history), 32'(b.hist));
          chk("train_pc", 32'(train_pc), 32'(b.pc));
        end
        last = b;
      end
    end else begin
      chk("hold_train", 32'({train_taken, train_mispredicted, train_history, train_pc}),
          32'(last));
    end
  end

  // One clock cycle of stimulus plus the model's view of what it does.
  task automatic cyc(input logic av, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] hist,
                     input logic tk, input logic rv, input logic rt, input logic fl);
    logic was_full, was_empty, mis;
    ent_t h;
    @(posedge clk);
    #2;
    alloc_valid = av; alloc_pc = pc; alloc_history = hist; alloc_taken = tk;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    mis = 1'b0;
    nx_err = rv && was_empty && !fl;
    nx_tv  = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (rv && !was_empty) begin
        h = mq[0];
        mis = (rt != h.tk);
        sb.push_back('{tk: rt, mis: mis, hist: h.hist, pc: h.pc});
        nx_tv = 1'b1;
        if (mis) mq.delete();
        else void'(mq.pop_front());
      end
      if (av && !was_full && !mis) mq.push_back('{pc: pc, hist: hist, tk: tk});
    end
    nx_count = mq.size();
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alloc(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] hist, input logic tk);
    cyc(1'b1, pc, hist, tk, 1'b0, 1'b0, 1'b0);
  endtask

  // Actual direction matching the oldest prediction (correct resolve).
  function automatic logic head_tk();
    return (mq.size() != 0) ? mq[0].tk : 1'b0;
  endfunction

  // Called within the cycle following a cyc(): reset lands before the edge.
  task automatic do_reset();
    #1;
    areset = 1'b1;
    alloc_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    mq.delete();
    sb.delete();
    nx_count = 0; nx_err = 1'b0; nx_tv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    areset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 areset = 1'b0;

    // Single correct prediction.
    alloc(7'h05, 7'h12, 1'b1);
    idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) idle();

    // Mispredict on oldest of three, then resolve while empty.
    alloc(7'h10, 7'h21, 1'b1);
    alloc(7'h11, 7'h22, 1'b0);
    alloc(7'h12, 7'h23, 1'b1);
    cyc(1'b1, 7'h13, 7'h24, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();

    // Empty with alloc and resolve together: resolve ignored, alloc taken.
    cyc(1'b1, 7'h30, 7'h31, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // Fill to full, drop a 9th, full with same-cycle resolve, then drain.
    for (int unsigned i = 0; i < 8; i++) alloc(7'(8'h40 + i), 7'(8'h50 + i), 1'(i));
    alloc(7'h7f, 7'h7f, 1'b1);
    cyc(1'b1, 7'h7e, 7'h7e, 1'b0, 1'b1, head_tk(), 1'b0);
    for (int unsigned i = 0; i < 8; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, head_tk(), 1'b0);
    idle();

    // Continuous alloc+resolve: constant count, pointers wrap.
    for (int unsigned i = 0; i < 3; i++) alloc(7'(i + 1), 7'(i + 9), 1'(i));
    for (int unsigned i = 0; i < 20; i++)
      cyc(1'b1, 7'(8'h60 + i), 7'(8'h20 + i), 1'(i >> 1), 1'b1, head_tk(), 1'b0);
    while (mq.size() != 0) cyc(1'b0, '0, '0, 1'b0, 1'b1, head_tk(), 1'b0);
    idle();

    // Flush beats alloc and resolve at count=4.
    for (int unsigned i = 0; i < 4; i++) alloc(7'(i + 2), 7'(i + 3), 1'b1);
    cyc(1'b1, 7'h55, 7'h55, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) idle();

    // Reset at count=5 with a resolve in flight.
    for (int unsigned i = 0; i < 5; i++) alloc(7'(i + 4), 7'(i + 5), 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    alloc(7'h2a, 7'h2b, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();

    // Randomized traffic, mostly-correct predictions so the queue fills.
    for (int unsigned i = 0; i < 500; i++) begin
      logic av, rv, rt, fl;
      av = ($urandom_range(99) < 60);
      rv = ($urandom_range(99) < 45);
      fl = ($urandom_range(99) < 3);
      rt = ($urandom_range(99) < 85) ? head_tk() : 1'($urandom);
      cyc(av, 7'($urandom), 7'($urandom), 1'($urandom), rv, rt, fl);
    end
    repeat (3) idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
